// File: rtl/ama_riscv_pkg.sv
// Shared constants and types for the ama_riscv core.
// Imem geometry, loader states and byte-lane masks.
package ama_riscv_pkg;

  localparam int IMEM_AW = 14;
  localparam int IMEM_WORDS = 1 << IMEM_AW;

  localparam logic [3:0] WEA_FULL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERR
  } ldr_state_e;

endpackage

// File: rtl/ama_riscv_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// Flags a word as ready when lane 3 fills or on the last byte.
module ama_riscv_byte_packer
  import ama_riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic        last,
  input  logic [7:0]  byte_in,
  output logic        wr,
  output logic [31:0] word,
  output logic [3:0]  mask
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] acc_q, acc_d;

  // Merge incoming byte, derive fill mask, advance lane.
  always_comb begin
    word = acc_q | ({24'b0, byte_in} << {lane_q, 3'b000});
    wr = push && (lane_q == 2'd3 || last);
    mask = 4'b0000;
    unique case (lane_q)
      2'd0: mask = 4'b0001;
      2'd1: mask = 4'b0011;
      2'd2: mask = 4'b0111;
      2'd3: mask = WEA_FULL;
    endcase
    lane_d = lane_q;
    acc_d = acc_q;
    if (clr) begin
      lane_d = 2'd0;
      acc_d = '0;
    end else if (push) begin
      if (wr) begin
        lane_d = 2'd0;
        acc_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        acc_d = word;
      end
    end
  end

  // Lane index and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      acc_q <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ama_riscv_imem_loader.sv
// Fills imem from a byte stream, one masked write per word.
// Reports done or address-overflow error to the boot controller.
module ama_riscv_imem_loader
  import ama_riscv_pkg::*;
#(
  parameter int AW = IMEM_AW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] byte_cnt,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          ena,
  output logic [3:0]    wea,
  output logic [AW-1:0] addra,
  output logic [31:0]   dina,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  ldr_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          ena_q, ena_d;
  logic [3:0]    wea_q, wea_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [31:0]   dina_q, dina_d;

  logic        accept;
  logic        last;
  logic        clr;
  logic        pk_wr;
  logic [31:0] pk_word;
  logic [3:0]  pk_mask;

  assign rx_ready = (state_q == LOAD) && (rem_q != '0);
  assign accept = rx_valid && rx_ready;
  assign last = (rem_q == CW'(1));
  assign clr = (state_q == IDLE) && start;

  assign ena = ena_q;
  assign wea = wea_q;
  assign addra = addra_q;
  assign dina = dina_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE) && !ena_q;
  assign err = (state_q == ERR);

  ama_riscv_byte_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .push    (accept),
    .last    (last),
    .byte_in (rx_data),
    .wr      (pk_wr),
    .word    (pk_word),
    .mask    (pk_mask)
  );

  // Next state, byte bookkeeping and write issue.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    ena_d = 1'b0;
    wea_d = 4'b0000;
    addra_d = addra_q;
    dina_d = dina_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d = byte_cnt;
          state_d = (byte_cnt == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          rem_d = rem_q - CW'(1);
          if (pk_wr) begin
            ena_d = 1'b1;
            wea_d = pk_mask;
            addra_d = addr_q;
            dina_d = pk_word;
            if (addr_q != ADDR_MAX) begin
              addr_d = addr_q + AW'(1);
            end
          end
          if (last) begin
            state_d = DONE;
          end else if (pk_wr && addr_q == ADDR_MAX) begin
            state_d = ERR;
          end
        end
      end
      DONE: begin
        if (!ena_q) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      ena_q <= 1'b0;
      wea_q <= 4'b0000;
      addra_q <= '0;
      dina_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      ena_q <= ena_d;
      wea_q <= wea_d;
      addra_q <= addra_d;
      dina_q <= dina_d;
    end
  end

endmodule

// File: tb/tb_ama_riscv_imem_loader.sv
// Self-checking bench for the imem loader.
// Table vectors, reset sequence and random loads vs a word model.
module tb_ama_riscv_imem_loader;

  localparam int AW = 14;
  localparam int CW = 16;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] byte_cnt = '0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          ena;
  logic [3:0]    wea;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic          busy;
  logic          done;
  logic          err;

  ama_riscv_imem_loader #(.AW(AW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .byte_cnt  (byte_cnt),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    w;
  } wr_t;

  typedef struct {
    int base;
    int cnt;
    bit gaps;
    int mode;
    int exp_wr;
    bit exp_done;
    bit exp_err;
    int exp_acc;
  } vec_t;

  int n_run = 0;
  int n_fail = 0;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] bq[$];

  int   mon_done = 0;
  int   mon_err = 0;
  int   mon_bad = 0;
  logic done_pe = 1'b0;
  logic done_se = 1'b0;
  logic prev_ena = 1'b0;
  logic start_e = 1'b0;

  int last_idx;
  int exp_acc;
  bit exp_done_b;
  bit exp_err_b;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) start_e <= start;

  always @(negedge clk) begin
    if (ena) got_q.push_back('{addra, dina, wea});
    if (!ena && wea != 4'b0000) mon_bad++;
    if (done && ena) mon_bad++;
    if (done) begin
      mon_done++;
      done_pe = prev_ena;
      done_se = start_e;
    end
    if (err) mon_err++;
    prev_ena = ena;
  end

  // Word-level reference: group bytes by 4, stop at the top address.
  task automatic model(input int b, input int n);
    exp_q.delete();
    exp_acc = n;
    exp_done_b = 1'b1;
    exp_err_b = 1'b0;
    for (int w = 0; 4 * w < n; w++) begin
      int  nb;
      wr_t e;
      nb = (n - 4 * w >= 4) ? 4 : n - 4 * w;
      e.a = AW'(b + w);
      e.d = '0;
      for (int k = 0; k < nb; k++)
        e.d |= 32'(bq[4 * w + k]) << (8 * k);
      e.w = 4'((1 << nb) - 1);
      exp_q.push_back(e);
      if (b + w == AMAX && n > 4 * (w + 1)) begin
        exp_err_b = 1'b1;
        exp_done_b = 1'b0;
        exp_acc = 4 * (w + 1);
        break;
      end
    end
  endtask

  task automatic fill_bytes(input int n, input int mode);
    bq.delete();
    for (int i = 0; i < n; i++) begin
      if (mode == 0) bq.push_back(8'(8'h11 * (i + 1)));
      else if (mode == 1) bq.push_back(8'(8'hA0 + i));
      else bq.push_back(8'($urandom));
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    got_q.delete();
    mon_done = 0;
    mon_err = 0;
    mon_bad = 0;
    done_pe = 1'b0;
    done_se = 1'b0;
  endtask

  task automatic run_load(input int b, input int n,
                          input bit gaps, input int mode);
    int idx;
    int guard;
    int stalls;
    fill_bytes(n, mode);
    model(b, n);
    clear_mon();
    @(negedge clk);
    base_addr = AW'(b);
    byte_cnt = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    guard = 0;
    stalls = 0;
    while (idx < n && busy && guard < 1000) begin
      rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      rx_data = bq[idx];
      if (rx_valid && rx_ready) idx++;
      else if (rx_valid) stalls++;
      @(negedge clk);
      guard++;
    end
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    last_idx = idx;
    check("no_timeout", 64'(guard < 1000), 64'd1);
    check("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("write%0d", i),
            {got_q[i].a, got_q[i].d, got_q[i].w},
            {exp_q[i].a, exp_q[i].d, exp_q[i].w});
    check("done_cnt", 64'(mon_done), 64'(exp_done_b));
    check("err_cnt", 64'(mon_err), 64'(exp_err_b));
    check("accepted", 64'(idx), 64'(exp_acc));
    check("wea_idle", 64'(mon_bad), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    if (exp_done_b)
      check("done_timing", 64'(n == 0 ? done_se : done_pe), 64'd1);
    if (!gaps && !exp_err_b)
      check("no_stall", 64'(stalls), 64'd0);
  endtask

  initial begin
    vec_t tbl[7];
    int   idx;
    int   guard;
    tbl[0] = '{'h0010, 8, 1'b0, 0, 2, 1'b1, 1'b0, 8};
    tbl[1] = '{'h0020, 6, 1'b0, 1, 2, 1'b1, 1'b0, 6};
    tbl[2] = '{'h0030, 12, 1'b1, 2, 3, 1'b1, 1'b0, 12};
    tbl[3] = '{'h3FFF, 8, 1'b0, 2, 1, 1'b0, 1'b1, 4};
    tbl[4] = '{'h0040, 0, 1'b0, 2, 0, 1'b1, 1'b0, 0};
    tbl[5] = '{'h3FFE, 8, 1'b0, 2, 2, 1'b1, 1'b0, 8};
    tbl[6] = '{'h3FFF, 3, 1'b1, 2, 1, 1'b1, 1'b0, 3};

    #12;
    check("reset_outs",
          64'({rx_ready, ena, wea, addra, dina, busy, done, err}),
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_load(tbl[i].base, tbl[i].cnt, tbl[i].gaps, tbl[i].mode);
      check("tbl_writes", 64'(got_q.size()), 64'(tbl[i].exp_wr));
      check("tbl_done", 64'(mon_done), 64'(tbl[i].exp_done));
      check("tbl_err", 64'(mon_err), 64'(tbl[i].exp_err));
      check("tbl_acc", 64'(last_idx), 64'(tbl[i].exp_acc));
      if (i == 0 && got_q.size() >= 2) begin
        check("t1_w0", {got_q[0].a, got_q[0].d, got_q[0].w},
              {14'h0010, 32'h44332211, 4'b1111});
        check("t1_w1", {got_q[1].a, got_q[1].d, got_q[1].w},
              {14'h0011, 32'h88776655, 4'b1111});
      end
      if (i == 1 && got_q.size() >= 2)
        check("t2_w1", {got_q[1].a, got_q[1].d, got_q[1].w},
              {14'h0021, 32'h0000A5A4, 4'b0011});
    end

    // Reset after 5 of 8 bytes.
    fill_bytes(8, 2);
    model('h0100, 8);
    clear_mon();
    @(negedge clk);
    base_addr = AW'('h0100);
    byte_cnt = CW'(8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < 5 && guard < 100) begin
      rx_valid = 1'b1;
      rx_data = bq[idx];
      if (rx_ready) idx++;
      @(negedge clk);
      guard++;
    end
    rx_valid = 1'b0;
    check("rst_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", 64'({ena, rx_ready, busy, done, err}), 64'd0);
    repeat (2) @(negedge clk);
    check("rst_mid_writes", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1)
      check("rst_mid_w0", {got_q[0].a, got_q[0].d, got_q[0].w},
            {exp_q[0].a, exp_q[0].d, exp_q[0].w});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_load('h0200, 8, 1'b0, 2);

    for (int r = 0; r < 20; r++) begin
      int b;
      b = ($urandom_range(0, 3) == 0) ? AMAX - int'($urandom_range(0, 6))
                                      : int'($urandom_range(0, AMAX));
      run_load(b, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
